// File: rtl/result_packer_pkg.sv
// result_packer_pkg
//   Shared constants and the closed-line record for the result packer.
//   LINE_LANES  : bytes per result line
//   LANE_W      : bits per lane (one result byte)
//   LINE_ADDR_W : line address width (byte address minus lane bits)
//   line_t      : one closed line as queued and presented to the memory
package result_packer_pkg;

  localparam int LINE_LANES  = 16;
  localparam int LANE_W      = 8;
  localparam int LANE_IDX_W  = $clog2(LINE_LANES);
  localparam int LINE_ADDR_W = 12;
  localparam int LINE_W      = LINE_LANES * LANE_W;

  typedef struct packed {
    logic [LINE_ADDR_W-1:0] addr;
    logic [LINE_W-1:0]      data;
    logic [LINE_LANES-1:0]  be;
  } line_t;

endpackage

// File: rtl/result_packer_fifo.sv
// result_packer_fifo (module sync_fifo)
//   Synchronous FIFO of closed lines; head is visible on rd_data.
//   clk, rst (sync, active-low), push/push_data, pop/rd_data,
//   full, empty, count.
//   A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; only occupied slots are ever presented.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/result_packer.sv
// result_packer
//   Packs the conv_pool byte write stream into 128-bit lines with byte
//   enables and queues closed lines towards a wide result memory.
//   clk, rst (sync, active-low)
//   output_we/output_addr/y : byte writes from conv_pool
//   flush                   : close the open partial line
//   wr_valid/wr_ready       : line write channel; wr_addr/wr_data/wr_be payload
//   busy                    : open line, pending flush or queued lines exist
//   overflow                : sticky, a closed line was dropped on a full queue
module result_packer
  import result_packer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int LANES      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  output_we,
  input  logic [ADDR_W-1:0]     output_addr,
  input  logic [DATA_W-1:0]     y,
  input  logic                  flush,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_W-5:0]     wr_addr,
  output logic [LINE_W-1:0]     wr_data,
  output logic [LINE_LANES-1:0] wr_be,
  output logic                  busy,
  output logic                  overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                   open_q, open_d;
  logic                   pend_q, pend_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d;
  logic [LINE_ADDR_W-1:0] line_q, line_d;
  logic [LINE_W-1:0]      data_q, data_d;
  logic [LINE_LANES-1:0]  be_q, be_d;

  logic [LINE_ADDR_W-1:0] in_line;
  logic [LANE_IDX_W-1:0]  in_lane;
  logic                   same_line;
  logic [LINE_W-1:0]      mrg_data;
  logic [LINE_LANES-1:0]  mrg_be;
  logic                   push, pop, push_acc;
  line_t                  push_line, head;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_cnt, cnt_nxt;

  assign in_line   = output_addr[ADDR_W-1:4];
  assign in_lane   = output_addr[3:0];
  assign same_line = open_q && (line_q == in_line);

  always_comb begin
    // The incoming byte lands on the open line if it matches, else on a fresh
    // all-zero line so unwritten lanes read back as 0.
    mrg_data = same_line ? data_q : '0;
    mrg_be   = same_line ? be_q   : '0;
    for (int k = 0; k < LINE_LANES; k++) begin
      if (in_lane == k[LANE_IDX_W-1:0]) begin
        mrg_data[k*LANE_W +: LANE_W] = y;
        mrg_be[k]                    = 1'b1;
      end
    end

    open_d    = open_q;
    pend_d    = pend_q;
    line_d    = line_q;
    data_d    = data_q;
    be_d      = be_q;
    push      = 1'b0;
    push_line = '{addr: line_q, data: data_q, be: be_q};

    if (output_we) begin
      if (!open_q || same_line) begin
        if ((&mrg_be) || flush || pend_q) begin
          push      = 1'b1;
          push_line = '{addr: in_line, data: mrg_data, be: mrg_be};
          open_d    = 1'b0;
          pend_d    = 1'b0;
        end else begin
          open_d = 1'b1;
          line_d = in_line;
          data_d = mrg_data;
          be_d   = mrg_be;
        end
      end else begin
        // Line change: old line leaves now; a flush in the same cycle is
        // deferred to the new line via pend.
        push   = 1'b1;
        open_d = 1'b1;
        line_d = in_line;
        data_d = mrg_data;
        be_d   = mrg_be;
        pend_d = flush;
      end
    end else if (open_q && (flush || pend_q)) begin
      push   = 1'b1;
      open_d = 1'b0;
      pend_d = 1'b0;
    end

    pop      = !fifo_empty && wr_ready;
    push_acc = push && (!fifo_full || pop);
    cnt_nxt  = fifo_cnt + CW'(push_acc) - CW'(pop);
    ovf_d    = ovf_q || (push && fifo_full && !pop);
    busy_d   = open_d || pend_d || (cnt_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      open_q <= 1'b0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      open_q <= open_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    line_q <= line_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

  sync_fifo #(
    .WIDTH ($bits(line_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_line),
    .pop       (pop),
    .rd_data   (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // Payload is forced to 0 when no beat is presented.
  assign wr_valid = !fifo_empty;
  assign wr_addr  = wr_valid ? head.addr : '0;
  assign wr_data  = wr_valid ? head.data : '0;
  assign wr_be    = wr_valid ? head.be   : '0;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_result_packer.sv
module tb_result_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         output_we;
  logic [15:0]  output_addr;
  logic [7:0]   y;
  logic         flush;
  logic         wr_valid;
  logic         wr_ready;
  logic [11:0]  wr_addr;
  logic [127:0] wr_data;
  logic [15:0]  wr_be;
  logic         busy;
  logic         overflow;

  result_packer dut (
    .clk         (clk),
    .rst         (rst),
    .output_we   (output_we),
    .output_addr (output_addr),
    .y           (y),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]  addr;
    logic [127:0] data;
    logic [15:0]  be;
  } beat_t;

  // Reference model: a byte array for the open line and a bounded queue of
  // expected beats.
  beat_t       mq[$];
  logic [7:0]  m_bytes[16];
  logic [15:0] m_be;
  logic [11:0] m_line;
  logic        m_open, m_pend, m_ovf;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic beat_t m_beat();
    beat_t b;
    b.addr = m_line;
    b.be   = m_be;
    b.data = '0;
    for (int k = 0; k < 16; k++) b.data[k*8 +: 8] = m_bytes[k];
    return b;
  endfunction

  function automatic void m_push(beat_t b);
    if (mq.size() < 4) mq.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  function automatic void m_new_line(logic [11:0] l);
    m_open = 1'b1;
    m_line = l;
    m_be   = '0;
    for (int k = 0; k < 16; k++) m_bytes[k] = 8'h00;
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_open = 1'b0;
    m_pend = 1'b0;
    m_ovf  = 1'b0;
    m_be   = '0;
    m_line = '0;
    for (int k = 0; k < 16; k++) m_bytes[k] = 8'h00;
  endfunction

  function automatic void m_edge(logic we, logic [15:0] a, logic [7:0] d, logic fl, logic rdy, logic rs);
    logic [11:0] l;
    logic [3:0]  ln;
    if (!rs) begin
      m_reset();
      return;
    end
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    l  = a[15:4];
    ln = a[3:0];
    if (we) begin
      if (!m_open || m_line == l) begin
        if (!m_open) m_new_line(l);
        m_bytes[ln] = d;
        m_be[ln]    = 1'b1;
        if (m_be == 16'hFFFF || fl || m_pend) begin
          m_push(m_beat());
          m_open = 1'b0;
          m_pend = 1'b0;
        end
      end else begin
        m_push(m_beat());
        m_new_line(l);
        m_bytes[ln] = d;
        m_be[ln]    = 1'b1;
        m_pend      = fl;
      end
    end else if (m_open && (fl || m_pend)) begin
      m_push(m_beat());
      m_open = 1'b0;
      m_pend = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    logic  v;
    beat_t h;
    v = (mq.size() != 0);
    h.addr = '0; h.data = '0; h.be = '0;
    if (v) h = mq[0];
    chk("wr_valid", 160'(wr_valid), 160'(v));
    chk("wr_addr",  160'(wr_addr),  160'(h.addr));
    chk("wr_data",  160'(wr_data),  160'(h.data));
    chk("wr_be",    160'(wr_be),    160'(h.be));
    chk("busy",     160'(busy),     160'(m_open || m_pend || mq.size() != 0));
    chk("overflow", 160'(overflow), 160'(m_ovf));
  endtask

  // One clock: drive inputs, compare current outputs, advance model and DUT.
  task automatic step(input logic we, input logic [15:0] a, input logic [7:0] d,
                      input logic fl, input logic rdy, input logic rs = 1'b1);
    output_we   = we;
    output_addr = a;
    y           = d;
    flush       = fl;
    wr_ready    = rdy;
    rst         = rs;
    check_outputs();
    m_edge(we, a, d, fl, rdy, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 8'h0, 1'b0, rdy);
  endtask

  initial begin
    rst = 1'b0; output_we = 1'b0; output_addr = '0; y = '0; flush = 1'b0; wr_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;

    // 1: full line
    for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 8'(i), 1'b0, 1'b1);
    chk("t1_valid", 160'(wr_valid), 160'(1'b1));
    chk("t1_addr",  160'(wr_addr),  160'(12'h000));
    chk("t1_data",  160'(wr_data),  160'(128'h0F0E0D0C0B0A09080706050403020100));
    chk("t1_be",    160'(wr_be),    160'(16'hFFFF));
    idle(2, 1'b1);
    chk("t1_busy",  160'(busy),     160'(1'b0));

    // 2: line switch then flush
    step(1'b1, 16'h0010, 8'h11, 1'b0, 1'b1);
    step(1'b1, 16'h0011, 8'h22, 1'b0, 1'b1);
    step(1'b1, 16'h0025, 8'h33, 1'b0, 1'b1);
    chk("t2_be1", 160'(wr_be), 160'(16'h0003));
    idle(3, 1'b1);
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
    chk("t2_be2",   160'(wr_be),          160'(16'h0020));
    chk("t2_byte5", 160'(wr_data[47:40]), 160'(8'h33));
    idle(2, 1'b1);

    // 3: lane overwrite
    step(1'b1, 16'h0030, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 16'h0030, 8'hBB, 1'b0, 1'b1);
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
    chk("t3_data", 160'(wr_data), 160'(128'hBB));
    idle(2, 1'b1);

    // 4: overflow with ready held low
    for (int i = 0; i < 80; i++) step(1'b1, 16'(i), 8'(i ^ 8'h5A), 1'b0, 1'b0);
    chk("t4_ovf",  160'(overflow), 160'(1'b1));
    chk("t4_head", 160'(wr_addr),  160'(12'h000));
    idle(6, 1'b1);
    chk("t4_ovf_sticky", 160'(overflow), 160'(1'b1));

    // 5: flush with line change in the same cycle
    step(1'b1, 16'h0040, 8'h44, 1'b0, 1'b1);
    step(1'b1, 16'h0051, 8'h55, 1'b1, 1'b1);
    chk("t5_be1", 160'(wr_be), 160'(16'h0001));
    step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
    chk("t5_be2", 160'(wr_be), 160'(16'h0002));
    idle(2, 1'b1);

    // 6: reset mid-line
    for (int i = 0; i < 7; i++) step(1'b1, 16'h0060 + 16'(i), 8'(i + 1), 1'b0, 1'b1);
    step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    chk("t6_busy",  160'(busy),     160'(1'b0));
    chk("t6_valid", 160'(wr_valid), 160'(1'b0));
    chk("t6_ovf",   160'(overflow), 160'(1'b0));
    idle(4, 1'b1);

    // Random: sequential line bursts with a stalling memory.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 7) != 0), 16'(i), 8'($urandom),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 1) == 1));

    // Random: scattered writes over a few lines, flushes and rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      a = {4'h0, 8'($urandom_range(7, 9)), 4'($urandom)};
      step(($urandom_range(0, 9) < 7), a, 8'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 999) != 0));
    end

    idle(8, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/result_packer.md
# result_packer

Write-side receiver for the conv_pool result port. It accepts the per-pixel byte stream that conv_pool emits on `output_we`/`output_addr`/`y` and packs the bytes into 128-bit result lines. Each line carries a 16-bit byte-enable mask, and the lines are presented to a wide result memory through a valid/ready write channel. It sits between conv_pool and the result store, replacing the byte-wide write model.

## Interface
Parameters:
- `DATA_W`, 8: result byte width; must match conv_pool `y`.
- `ADDR_W`, 16: byte address width; must match conv_pool `output_addr`.
- `LANES`, 16: bytes per line. Must be a power of 2, so line width is 128.
- `FIFO_DEPTH`, 4: closed-line queue depth. Must be a power of 2, ≥2.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-low.
- `output_we`, in, 1: byte write strobe from conv_pool.
- `output_addr`, in, ADDR_W: byte address.
- `y`, in, DATA_W: result byte.
- `flush`, in, 1: single-cycle pulse that closes the open partial line.
- `wr_valid`, out, 1: a line beat is presented.
- `wr_ready`, in, 1: the result memory accepts the beat.
- `wr_addr`, out, ADDR_W-4: line address, equal to `output_addr[ADDR_W-1:4]`.
- `wr_data`, out, 128: line data; lane k occupies `[8k+7:8k]`.
- `wr_be`, out, 16: byte enables; bit k corresponds to lane k.
- `busy`, out, 1: the open line or the queue is non-empty.
- `overflow`, out, 1: sticky flag; a closed line was dropped because the queue was full.

## Operation
Address split:
- line = `output_addr[ADDR_W-1:4]`
- lane = `output_addr[3:0]`

The accumulator holds {open, line, data, be}.

On `output_we`:
- **Accumulator empty:** open the line and set the lane.
- **Same line:** write the lane. A repeat write to a lane overwrites the data byte; its be bit stays 1.
- **Different line:** push the current line to the queue, then open the new line with this byte.
- **be becomes 0xFFFF:** push the line in the same cycle; the accumulator is empty in the next cycle.

On `flush`:
- Accumulator open: push the line.
- Accumulator empty: no effect.

`flush` together with `output_we` in the same cycle:
- Byte targets the open line, or the accumulator is empty: merge the byte, then push the line.
- Byte targets a different line: push the old line this cycle, open the new line with the byte, and set `flush_pend`. The new line is pushed on the next cycle.
- While `flush_pend` is set, a new `output_we` to that same line merges before the push.

Queue behaviour:
- The queue is a FIFO. Its head drives `wr_*`.
- A beat transfers on `wr_valid && wr_ready`.
- Push and pop in the same cycle are legal when the queue is full.
- A push when the queue is full and there is no pop drops the line and sets `overflow`. conv_pool cannot be stalled, so overflow is reported, not prevented. Only `rst` clears `overflow`.
- Unwritten lanes of a line are 0 in `wr_data`.

## Timing
- **Reset** (`rst`=0 at an edge): accumulator and queue are empty and `flush_pend`=0. `wr_valid`, `wr_addr`, `wr_data`, `wr_be`, `busy` and `overflow` are all 0 in the following cycle. A partially filled line is discarded.
- **Latency:** a push at edge N gives `wr_valid`=1 during cycle N+1. The `wr_*` outputs are registered or derived from FIFO storage, never combinational from `output_we`.
- **Hold rule:** `wr_addr`, `wr_data` and `wr_be` hold stable while `wr_valid && !wr_ready`.
- **Idle outputs:** `wr_addr`, `wr_data` and `wr_be` are 0 whenever `wr_valid`=0.
- **Throughput:** sustained at one line per 16 `output_we` cycles, with no bubbles when `wr_ready`=1.
- **busy:** `busy` = open | `flush_pend` | (queue count ≠ 0), registered.

## Structure
- Package `result_packer_pkg` holds:
  - `LINE_LANES`, `LANE_W` and `LINE_ADDR_W` constants.
  - `line_t` struct {addr, data[127:0], be[15:0]}.
- Sub-module `sync_fifo`: parameterized on width and depth, with full and empty flags, and it allows push and pop in the same cycle when full. It stores `line_t`.
- Top-level logic: the accumulator, the push and flush control including `flush_pend`, and `overflow`.

## Test plan
1. **Full line:** writes to 0x0000–0x000F with y = 0x00–0x0F, `wr_ready`=1 → one beat with `wr_addr`=0x000, `wr_data`=0x0F0E…0100, `wr_be`=0xFFFF. `wr_valid` is high in the cycle after the last write, and `busy`=0 afterward.
2. **Line switch and flush:** writes 0x0010=0x11, 0x0011=0x22, then 0x0025=0x33 → beat with `wr_addr`=0x001, `wr_be`=0x0003. A later `flush` → beat with `wr_addr`=0x002, `wr_be`=0x0020, and byte 5 = 0x33.
3. **Lane overwrite:** 0x0030=0xAA, then 0x0030=0xBB, then `flush` → `wr_be`=0x0001 and byte 0 = 0xBB.
4. **Overflow:** `wr_ready`=0 while 5 full lines are written (line addresses 0–4) → 4 beats queued, `overflow`=1, and line 4 is lost. Raising `wr_ready` → lines 0–3 delivered in order, and `overflow` stays 1.
5. **Flush with line change:** line 0x004 open with lane 0; `flush` and `output_we` to 0x0051 in the same cycle → back-to-back beats line 0x004 (`wr_be`=0x0001), then line 0x005 (`wr_be`=0x0002).
6. **Reset mid-line:** 7 bytes written to line 0x006, then `rst`=0 for one edge → `busy`=0 and `wr_valid`=0, and no beat is ever emitted for line 0x006.
